// File: rtl/uart_tx_arbiter.sv
// Arbitrates the keyboard and response byte streams onto one UART TX, holding the grant for escape sequences.
// Define ARB_KBD_PRIORITY_EN to give the keyboard fixed priority on idle ties instead of round robin.
module uart_tx_arbiter #(
  parameter int          LOCK_TIMEOUT = 100000,
  parameter logic [7:0]  ESC_CODE     = 8'h1b,
  parameter logic [7:0]  ESC_Y_CODE   = 8'h59
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] kbd_data,
  input  logic       kbd_valid,
  output logic       kbd_ready,
  input  logic [7:0] rsp_data,
  input  logic       rsp_valid,
  output logic       rsp_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       lock_active,
  output logic       lock_owner,
  output logic       lock_timeout
);

  localparam int TW = $clog2(LOCK_TIMEOUT) + 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(LOCK_TIMEOUT - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_LOCK = 1'b1;

  logic [0:0]    state;
  logic          last_grant;
  logic [1:0]    remaining;
  logic          seq_first;
  logic [TW-1:0] timer;

  logic       out_free;
  logic       expired;
  logic       sel_rsp;
  logic       acc_k;
  logic       acc_r;
  logic       acc;
  logic [7:0] acc_data;

  assign out_free    = !tx_valid || tx_ready;
  assign expired     = (state == S_LOCK) && (timer == TIMER_MAX);
  assign lock_active = (state == S_LOCK);

  always_comb begin
    sel_rsp   = 1'b0;
    kbd_ready = 1'b0;
    rsp_ready = 1'b0;
    if (state == S_IDLE) begin
`ifdef ARB_KBD_PRIORITY_EN
      sel_rsp = rsp_valid && !kbd_valid;
`else
      // last_grant: 0 = keyboard, 1 = response; a tie goes to the other one
      sel_rsp = rsp_valid && (!kbd_valid || !last_grant);
`endif
      kbd_ready = out_free && kbd_valid && !sel_rsp;
      rsp_ready = out_free && sel_rsp;
    end else if (!expired) begin
      kbd_ready = out_free && !lock_owner;
      rsp_ready = out_free && lock_owner;
    end
  end

  assign acc_k    = kbd_valid && kbd_ready;
  assign acc_r    = rsp_valid && rsp_ready;
  assign acc      = acc_k || acc_r;
  assign acc_data = acc_r ? rsp_data : kbd_data;

  // Output register and arbitration state update on the same edge as the handshake
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_valid     <= 1'b0;
      tx_data      <= 8'h00;
      state        <= S_IDLE;
      lock_owner   <= 1'b0;
      lock_timeout <= 1'b0;
      last_grant   <= 1'b1;
      remaining    <= 2'd0;
      seq_first    <= 1'b0;
      timer        <= '0;
    end else begin
      lock_timeout <= 1'b0;
      if (acc) begin
        tx_data  <= acc_data;
        tx_valid <= 1'b1;
      end else if (tx_ready) begin
        tx_valid <= 1'b0;
      end

      if (state == S_IDLE) begin
        if (acc) begin
          last_grant <= acc_r;
          if (acc_data == ESC_CODE) begin
            state      <= S_LOCK;
            lock_owner <= acc_r;
            remaining  <= 2'd1;
            seq_first  <= 1'b1;
            timer      <= '0;
          end
        end
      end else begin
        if (expired) begin
          state        <= S_IDLE;
          lock_timeout <= 1'b1;
        end else if (acc) begin
          timer     <= '0;
          seq_first <= 1'b0;
          if (seq_first && (acc_data == ESC_Y_CODE)) begin
            remaining <= 2'd2;
          end else if (remaining == 2'd1) begin
            remaining  <= 2'd0;
            state      <= S_IDLE;
            last_grant <= lock_owner;
          end else begin
            remaining <= remaining - 2'd1;
          end
        end else begin
          timer <= timer + TW'(1);
        end
      end
    end
  end

endmodule
